// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - FSM state encoding (IDLE, CALC, DONE)
//   - minterm indices of the 3-to-8 decoder output that form the difference
//     bit {1,2,4,7} and the next-borrow bit {1,2,3,7}. The minterm index is
//     {a,b,c} with a as MSB.
//   - masks built from those indices and a one-hot test helper
// -----------------------------------------------------------------------------
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Difference bit = odd parity of {a,b,c}
   localparam int unsigned M_D0 = 1;
   localparam int unsigned M_D1 = 2;
   localparam int unsigned M_D2 = 4;
   localparam int unsigned M_D3 = 7;

   // Borrow out of a - b - c
   localparam int unsigned M_B0 = 1;
   localparam int unsigned M_B1 = 2;
   localparam int unsigned M_B2 = 3;
   localparam int unsigned M_B3 = 7;

   localparam logic [7:0] D_MASK = (8'd1 << M_D0) | (8'd1 << M_D1) |
                                   (8'd1 << M_D2) | (8'd1 << M_D3);
   localparam logic [7:0] B_MASK = (8'd1 << M_B0) | (8'd1 << M_B1) |
                                   (8'd1 << M_B2) | (8'd1 << M_B3);

   // True when exactly one bit of v is set
   function automatic logic is_onehot8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return (n == 4'd1);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Operand and result handshakes of the bit-serial subtractor.
//   in_valid/in_ready  : operand transfer (in_x minuend, in_y subtrahend,
//                        in_bin initial borrow)
//   out_valid/out_ready: result transfer (out_diff, out_bout borrow-out)
// Modports: master = producer of operands / consumer of results,
//           slave  = the subtractor.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_x;
   logic [W-1:0] in_y;
   logic         in_bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_diff;
   logic         out_bout;

   modport master (
      output in_valid, in_x, in_y, in_bin, out_ready,
      input  in_ready, out_valid, out_diff, out_bout
   );

   modport slave (
      input  in_valid, in_x, in_y, in_bin, out_ready,
      output in_ready, out_valid, out_diff, out_bout
   );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial W-bit subtractor. Each CALC cycle the current minuend bit,
// subtrahend bit and running borrow are sent to an external 3-to-8 minterm
// decoder; the returned one-hot minterms are ORed into the difference bit and
// the next borrow. The difference is shifted into a result register LSB first.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       operand / result valid-ready handshakes
//   dec_a/dec_b/dec_c to decoder: minuend bit, subtrahend bit, borrow
//                     (0 outside CALC)
//   dec_y             decoder outputs {y7..y0}, expected one-hot
//   err               sticky one-hot error flag
//
// Build option: SERIAL_SUB_ONEHOT_CHECK_EN enables the one-hot check on
// dec_y during CALC; when undefined err is tied low.
// -----------------------------------------------------------------------------
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus,
   output logic                dec_a,
   output logic                dec_b,
   output logic                dec_c,
   input  logic [7:0]          dec_y,
   output logic                err
);

   localparam int CNT_W = $clog2(W);

   state_t             state_q;
   state_t             state_d;
   logic [W-1:0]       x_sh;
   logic [W-1:0]       y_sh;
   logic [W-1:0]       diff_sh;
   logic               borrow;
   logic [CNT_W-1:0]   cnt;
   logic [W-1:0]       res_diff;
   logic               res_bout;

   logic               in_acc;
   logic               calc;
   logic               last;
   logic               d_bit;
   logic               b_next;

   assign calc   = (state_q == CALC);
   assign in_acc = (state_q == IDLE) && bus.in_valid;
   assign last   = (cnt == CNT_W'(W - 1));

   // Minterm OR pair: any set minterm inside the mask raises the bit
   assign d_bit  = |(dec_y & D_MASK);
   assign b_next = |(dec_y & B_MASK);

   // Decoder drive comes from registered state only, gated to CALC
   assign dec_a = calc & x_sh[0];
   assign dec_b = calc & y_sh[0];
   assign dec_c = calc & borrow;

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_diff  = res_diff;
   assign bus.out_bout  = res_bout;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.in_valid) state_d = CALC;
         CALC: if (last) state_d = DONE;
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Serial datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_sh     <= '0;
         y_sh     <= '0;
         diff_sh  <= '0;
         borrow   <= 1'b0;
         cnt      <= '0;
         res_diff <= '0;
         res_bout <= 1'b0;
      end else if (in_acc) begin
         x_sh    <= bus.in_x;
         y_sh    <= bus.in_y;
         borrow  <= bus.in_bin;
         cnt     <= '0;
         diff_sh <= '0;
      end else if (calc) begin
         x_sh    <= {1'b0, x_sh[W-1:1]};
         y_sh    <= {1'b0, y_sh[W-1:1]};
         diff_sh <= {d_bit, diff_sh[W-1:1]};
         borrow  <= b_next;
         cnt     <= cnt + 1'b1;
         // The result register is loaded with the final shifted value so it
         // holds steady through DONE and the following IDLE/CALC cycles.
         if (last) begin
            res_diff <= {d_bit, diff_sh[W-1:1]};
            res_bout <= b_next;
         end
      end
   end

`ifdef SERIAL_SUB_ONEHOT_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (calc && !is_onehot8(dec_y)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Bench for serial_subtractor (W=8) with a behavioural 3-to-8 decoder.
// Expected results are queued on operand accept and compared on result.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
   } vec_t;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       dec_a, dec_b, dec_c;
   logic [7:0] dec_y;
   logic       err;
   logic       force_bad;

   int n_pass;
   int n_total;

   exp_t sb[$];

   serial_subtractor_if #(.W(W)) bus ();

   serial_subtractor #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .dec_a (dec_a),
      .dec_b (dec_b),
      .dec_c (dec_c),
      .dec_y (dec_y),
      .err   (err)
   );

   // External minterm decoder, index {a,b,c}
   assign dec_y = force_bad ? 8'h03 : (8'd1 << {dec_a, dec_b, dec_c});

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
      logic [W:0] t;
      exp_t e;
      t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
      e.diff = t[W-1:0];
      e.bout = t[W];
      return e;
   endfunction

   // Present operands when in_ready; returns at the negedge after the accept edge
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic bin, input bit push);
      int n;
      n = 0;
      while (!bus.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_x     = x;
      bus.in_y     = y;
      bus.in_bin   = bin;
      if (push) sb.push_back(model(x, y, bin));
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Wait for out_valid counting edges since accept; optionally check decoder drive
   task automatic wait_done(input logic [W-1:0] x, input logic [W-1:0] y,
                            input bit check_dec, input bit check_lat);
      int cycles;
      cycles = 0;
      while (!bus.out_valid && cycles < 4 * W) begin
         if (check_dec && cycles < W) begin
            chk("dec_a", {31'd0, dec_a}, {31'd0, x[cycles]});
            chk("dec_b", {31'd0, dec_b}, {31'd0, y[cycles]});
            chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
         end
         @(negedge clk);
         cycles++;
      end
      if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
      else if (check_lat) chk("latency", cycles, W);
   endtask

   // Compare result against scoreboard (if check) and hand it off
   task automatic finish_op(input bit check);
      exp_t e;
      logic [W-1:0] held;
      if (check) begin
         if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("out_diff", {24'd0, bus.out_diff}, {24'd0, e.diff});
            chk("out_bout", {31'd0, bus.out_bout}, {31'd0, e.bout});
         end
         chk("dec_idle_done", {29'd0, dec_a, dec_b, dec_c}, 32'd0);
      end
      held = bus.out_diff;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (check) begin
         chk("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
         chk("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
         chk("diff_kept_idle", {24'd0, bus.out_diff}, {24'd0, held});
      end
   endtask

   initial begin
      vec_t tbl[8];
      exp_t e;
      exp_t ea;
      logic [W-1:0] rx, ry;
      logic rb;

      n_pass = 0;
      n_total = 0;
      force_bad = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_x = '0;
      bus.in_y = '0;
      bus.in_bin = 1'b0;
      bus.out_ready = 1'b0;

      tbl[0] = '{x: 8'h5A, y: 8'h23, bin: 1'b0, diff: 8'h37, bout: 1'b0};
      tbl[1] = '{x: 8'h00, y: 8'h01, bin: 1'b0, diff: 8'hFF, bout: 1'b1};
      tbl[2] = '{x: 8'h10, y: 8'h10, bin: 1'b1, diff: 8'hFF, bout: 1'b1};
      tbl[3] = '{x: 8'h80, y: 8'h7F, bin: 1'b1, diff: 8'h00, bout: 1'b0};
      tbl[4] = '{x: 8'hC3, y: 8'hC3, bin: 1'b0, diff: 8'h00, bout: 1'b0};
      for (int i = 5; i < 8; i++) begin
         rx = 8'($urandom_range(0, 255));
         ry = 8'($urandom_range(0, 255));
         rb = 1'($urandom_range(0, 1));
         e  = model(rx, ry, rb);
         tbl[i] = '{x: rx, y: ry, bin: rb, diff: e.diff, bout: e.bout};
      end

      // Reset state
      rst_n = 1'b0;
      #12;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_diff", {24'd0, bus.out_diff}, 32'd0);
      chk("rst_out_bout", {31'd0, bus.out_bout}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_dec", {29'd0, dec_a, dec_b, dec_c}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven operations; the table's constant results are also
      // cross-checked against the queued model result
      for (int i = 0; i < 8; i++) begin
         e = model(tbl[i].x, tbl[i].y, tbl[i].bin);
         chk("table_vs_model", {23'd0, e.bout, e.diff}, {23'd0, tbl[i].bout, tbl[i].diff});
         start_op(tbl[i].x, tbl[i].y, tbl[i].bin, 1'b1);
         wait_done(tbl[i].x, tbl[i].y, 1'b1, 1'b1);
         chk("tbl_diff", {24'd0, bus.out_diff}, {24'd0, tbl[i].diff});
         chk("tbl_bout", {31'd0, bus.out_bout}, {31'd0, tbl[i].bout});
         finish_op(1'b1);
      end

      // Back-pressure with a second request during CALC/DONE
      start_op(8'h3C, 8'h05, 1'b0, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_x = 8'h44;
      bus.in_y = 8'h11;
      bus.in_bin = 1'b1;
      wait_done(8'h3C, 8'h05, 1'b1, 1'b1);
      ea = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("hold_diff", {24'd0, bus.out_diff}, {24'd0, ea.diff});
         chk("hold_bout", {31'd0, bus.out_bout}, {31'd0, ea.bout});
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("hold_back_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
      sb.push_back(model(8'h44, 8'h11, 1'b1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_done(8'h44, 8'h11, 1'b1, 1'b1);
      finish_op(1'b1);

      // Reset in the middle of CALC
      start_op(8'hAA, 8'h11, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("abort_dec", {29'd0, dec_a, dec_b, dec_c}, 32'd0);
      chk("abort_out_diff", {24'd0, bus.out_diff}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_op(8'h0F, 8'h01, 1'b0, 1'b1);
      wait_done(8'h0F, 8'h01, 1'b1, 1'b1);
      chk("post_abort_diff", {24'd0, bus.out_diff}, 32'h0E);
      finish_op(1'b1);

      // Corrupt decoder output for one CALC cycle
      start_op(8'h00, 8'h00, 1'b0, 1'b0);
      force_bad = 1'b1;
      @(negedge clk);
      force_bad = 1'b0;
`ifdef SERIAL_SUB_ONEHOT_CHECK_EN
      chk("err_set", {31'd0, err}, 32'd1);
`else
      chk("err_tied", {31'd0, err}, 32'd0);
`endif
      wait_done(8'h00, 8'h00, 1'b0, 1'b0);
      finish_op(1'b0);
      repeat (3) @(negedge clk);
`ifdef SERIAL_SUB_ONEHOT_CHECK_EN
      chk("err_sticky", {31'd0, err}, 32'd1);
`else
      chk("err_still_0", {31'd0, err}, 32'd0);
`endif
      rst_n = 1'b0;
      #1;
      chk("err_reset", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
